// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   Op codes (3-bit), FSM state encoding.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the MDU datapath.
//   acc_i    in  2*WIDTH+1  accumulator {upper W+1 bits, lower W bits}
//   opnd_i   in  WIDTH      multiplicand (mult) or divisor (div), magnitude
//   is_div_i in  1          1: restoring shift-subtract, 0: shift-add
//   acc_o    out 2*WIDTH+1  accumulator after this step
// Mult: lower half starts as multiplier, upper collects partial product,
//   whole thing shifts right. Div: lower half starts as dividend, shifts
//   left into the partial remainder, quotient bits enter at bit 0.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             is_div_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] shl;

  always_comb begin
    sum  = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    // Partial remainder never exceeds W bits, so dropping acc_i[2W] is safe.
    shl  = {acc_i[2*WIDTH-1:0], 1'b0};
    diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
    if (is_div_i) begin
      if (shl[2*WIDTH:WIDTH] >= {1'b0, opnd_i})
        acc_o = {diff, shl[WIDTH-1:1], 1'b1};
      else
        acc_o = shl;
    end else begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
//   MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; MTHI/MTLO write in one.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   issue request, honoured only when idle
//   op     in   3-bit op code (mdu_pkg)
//   a, b   in   WIDTH operands (rs, rt)
//   cancel in   abort in-flight op (present only with MDU_CANCEL_EN)
//   busy   out  multi-cycle op in progress
//   done   out  one-cycle pulse after HI/LO written by a multi-cycle op
//   hi, lo out  HI/LO registers
// Build option: define MDU_CANCEL_EN to add the cancel port.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int AW = 2*WIDTH+1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // product/quotient needs negation
  logic             neg_rem_q, neg_rem_d;   // remainder takes dividend sign
  logic             dz_q, dz_d;             // divide by zero
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AW-1:0]      acc_step;
  logic               kill;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;

    prod_fix  = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    // Divide by zero keeps the raw all-ones quotient regardless of signs.
    quo_fix   = (neg_res_q && !dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          case (op)
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d   = S_CALC;
              count_d   = '0;
              is_div_d  = op[1];
              opnd_d    = op[1] ? b_abs : a_abs;
              acc_d     = {{(WIDTH+1){1'b0}}, (op[1] ? a_abs : b_abs)};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dz_d      = (b == '0);
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_step;
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!kill) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32).
//   Directed corner cases plus random ops against a plain-arithmetic model.
//   Define MDU_CANCEL_EN to also exercise the cancel port.
module tb_mdu_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          cancel;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} after op, straight from the arithmetic definition.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, y,
                                         input logic [63:0] cur);
    int sx, sy;
    longint lx, ly;
    longint unsigned ux, uy;
    logic [31:0] q, r;
    sx = int'(x); sy = int'(y);
    lx = longint'(sx); ly = longint'(sy);
    ux = 64'(x); uy = 64'(y);
    case (o)
      3'd0: return 64'(lx * ly);
      3'd1: return 64'(ux * uy);
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = 32'(sx / sy); r = 32'(sx % sy);
        return {r, q};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      3'd4: return {x, cur[31:0]};
      3'd5: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  // Multi-cycle op; optionally fires a MULT start at busy cycle 'inject'.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, input int inject);
    logic [63:0] e;
    int cyc;
    bit stable;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e = ref_md(o, x, y, {mhi, mlo});
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0; stable = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (hi !== mhi || lo !== mlo) stable = 1'b0;
      if (cyc == inject) begin
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mhi = e[63:32]; mlo = e[31:0];
    chk("busy_len", 64'(cyc), 64'(W+1));
    chk("hilo_stable", 64'(stable), 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    chk("hi", 64'(hi), 64'(mhi));
    chk("lo", 64'(lo), 64'(mlo));
    @(negedge clk);
    chk("done_clear", 64'(done), 64'd0);
  endtask

  // Single-cycle path: MTHI/MTLO or an ignored no-op code.
  task automatic mt_op(input logic [2:0] o, input logic [31:0] x);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = $urandom;
    e = ref_md(o, x, 32'h0, {mhi, mlo});
    @(negedge clk);
    start = 1'b0;
    mhi = e[63:32]; mlo = e[31:0];
    chk("mt_hi", 64'(hi), 64'(mhi));
    chk("mt_lo", 64'(lo), 64'(mlo));
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd3, 32'd7, 32'd0, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, -1);
    mt_op(3'd4, 32'h1234);
    mt_op(3'd5, 32'h5678);
    mt_op(3'd6, 32'hDEAD);
    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, 10);

    // Reset during CALC: state returns to reset values immediately.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mt_op(3'd4, 32'hAAAA);

`ifdef MDU_CANCEL_EN
    // Cancel mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_busy", 64'(busy), 64'd0);
    chk("cxl_hi", 64'(hi), 64'(mhi));
    chk("cxl_lo", 64'(lo), 64'(mlo));
    chk("cxl_done", 64'(done), 64'd0);
    // Cancel coinciding with the final FIX edge.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_fix_busy", 64'(busy), 64'd0);
    chk("cxl_fix_lo", 64'(lo), 64'(mlo));
    chk("cxl_fix_done", 64'(done), 64'd0);
    // Cancel in IDLE blocks an MTHI.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cxl_mthi", 64'(hi), 64'(mhi));
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro <= 3'd3) run_op(ro, rnd_val(), rnd_val(), -1);
      else mt_op(ro, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
